// File: rtl/btb_update_scheduler.sv
// Sole writer of the BTB: queues taken-branch installs from ID and
// sequences full-table invalidation sweeps over one valid/ready port.
module btb_update_scheduler #(
  parameter int DEPTH      = 4,
  parameter int SETS       = 512,
  parameter int INDEX_BITS = 9,
  parameter int TAG_BITS   = 21
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  STALL,
  input  logic                  upd_valid_IN_ID,
  input  logic [31:0]           upd_PC_IN_ID,
  input  logic                  upd_taken_IN_ID,
  input  logic [31:0]           upd_target_IN_ID,
  output logic                  upd_ready_OUT,
  input  logic                  inval_all_IN,
  output logic                  wr_valid_OUT,
  output logic                  wr_op_OUT,
  output logic [INDEX_BITS-1:0] wr_index_OUT,
  output logic [TAG_BITS-1:0]   wr_tag_OUT,
  output logic [31:0]           wr_target_OUT,
  input  logic                  wr_ready_IN,
  output logic                  busy_OUT,
  output logic                  sweep_done_OUT,
  output logic [15:0]           drop_count_OUT
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DRAIN,
    S_SWEEP
  } state_t;

  typedef struct packed {
    logic [INDEX_BITS-1:0] idx;
    logic [TAG_BITS-1:0]   tag;
    logic [31:0]           tgt;
  } ent_t;

  state_t                state_q, state_d;
  ent_t                  mem_q [DEPTH];
  ent_t                  wr_q, wr_d;
  ent_t                  in_ent;
  logic [PW-1:0]         head_q, tail_q, head_nxt;
  logic [CW-1:0]         cnt_q;
  logic [INDEX_BITS-1:0] swc_q, swc_d;
  logic [15:0]           drop_q;
  logic                  pend_q, pend_d;
  logic                  wv_q, wv_d;
  logic                  op_q, op_d;
  logic                  done_q, done_d;
  logic                  req, enq, drop, hs;
  logic                  pop, flush, go_sweep, sweep_req;
  logic                  unused_pc;

  assign unused_pc = ^upd_PC_IN_ID[1:0];

  assign in_ent = '{
    idx: upd_PC_IN_ID[INDEX_BITS+1:2],
    tag: upd_PC_IN_ID[31:INDEX_BITS+2],
    tgt: upd_target_IN_ID
  };

  assign upd_ready_OUT = (cnt_q < CW'(DEPTH))
                       && (state_q != S_SWEEP)
                       && !pend_q;

  assign req       = upd_valid_IN_ID & upd_taken_IN_ID & ~STALL;
  assign enq       = req & upd_ready_OUT;
  assign drop      = req & ~upd_ready_OUT;
  assign hs        = wv_q & wr_ready_IN;
  assign sweep_req = pend_q | inval_all_IN;
  assign head_nxt  = head_q + PW'(1);

  always_comb begin
    state_d  = state_q;
    wv_d     = wv_q;
    op_d     = op_q;
    wr_d     = wr_q;
    swc_d    = swc_q;
    done_d   = 1'b0;
    pop      = 1'b0;
    go_sweep = 1'b0;
    pend_d   = pend_q | (inval_all_IN & (state_q != S_SWEEP));
    unique case (state_q)
      S_IDLE: begin
        if (sweep_req) begin
          go_sweep = 1'b1;
        end else if (cnt_q != '0) begin
          state_d = S_DRAIN;
          wv_d    = 1'b1;
          op_d    = 1'b0;
          wr_d    = mem_q[head_q];
        end else if (enq) begin
          state_d = S_DRAIN;
          wv_d    = 1'b1;
          op_d    = 1'b0;
          wr_d    = in_ent;
        end
      end
      S_DRAIN: begin
        if (hs) begin
          pop = 1'b1;
          if (sweep_req) begin
            go_sweep = 1'b1;
          end else if (cnt_q > CW'(1)) begin
            wr_d = mem_q[head_nxt];
          end else if (enq) begin
            // the only remaining entry arrives this cycle: bypass it
            wr_d = in_ent;
          end else begin
            state_d = S_IDLE;
            wv_d    = 1'b0;
            wr_d    = '0;
          end
        end
      end
      S_SWEEP: begin
        if (hs) begin
          if (swc_q == INDEX_BITS'(SETS - 1)) begin
            state_d = S_IDLE;
            wv_d    = 1'b0;
            op_d    = 1'b0;
            wr_d    = '0;
            swc_d   = '0;
            done_d  = 1'b1;
            pend_d  = 1'b0;
          end else begin
            swc_d    = swc_q + INDEX_BITS'(1);
            wr_d.idx = swc_q + INDEX_BITS'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (go_sweep) begin
      state_d = S_SWEEP;
      wv_d    = 1'b1;
      op_d    = 1'b1;
      wr_d    = '0;
      swc_d   = '0;
    end
  end

  assign flush = go_sweep;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= S_IDLE;
      wv_q    <= 1'b0;
      op_q    <= 1'b0;
      wr_q    <= '0;
      swc_q   <= '0;
      done_q  <= 1'b0;
      pend_q  <= 1'b0;
      drop_q  <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      wv_q    <= wv_d;
      op_q    <= op_d;
      wr_q    <= wr_d;
      swc_q   <= swc_d;
      done_q  <= done_d;
      pend_q  <= pend_d;
      if (drop && (drop_q != 16'hFFFF)) begin
        drop_q <= drop_q + 16'd1;
      end
      if (flush) begin
        head_q <= '0;
        tail_q <= '0;
        cnt_q  <= '0;
      end else begin
        if (enq) tail_q <= tail_q + PW'(1);
        if (pop) head_q <= head_nxt;
        cnt_q <= cnt_q + CW'(enq) - CW'(pop);
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (enq) begin
      mem_q[tail_q] <= in_ent;
    end
  end

  assign wr_valid_OUT   = wv_q;
  assign wr_op_OUT      = op_q;
  assign wr_index_OUT   = wr_q.idx;
  assign wr_tag_OUT     = wr_q.tag;
  assign wr_target_OUT  = wr_q.tgt;
  assign busy_OUT       = (state_q != S_IDLE) || (cnt_q != '0);
  assign sweep_done_OUT = done_q;
  assign drop_count_OUT = drop_q;

endmodule

// File: tb/tb_btb_update_scheduler.sv
// Bench for btb_update_scheduler: vector table, sweep/reset sequences
// and a randomized run against a queue-based reference model.
module tb_btb_update_scheduler;

  logic        CLK = 1'b0;
  logic        RESET, STALL;
  logic        upd_valid_IN_ID, upd_taken_IN_ID;
  logic [31:0] upd_PC_IN_ID, upd_target_IN_ID;
  logic        upd_ready_OUT, inval_all_IN;
  logic        wr_valid_OUT, wr_op_OUT, wr_ready_IN;
  logic [8:0]  wr_index_OUT;
  logic [20:0] wr_tag_OUT;
  logic [31:0] wr_target_OUT;
  logic        busy_OUT, sweep_done_OUT;
  logic [15:0] drop_count_OUT;

  int checks = 0;
  int errors = 0;

  localparam logic [31:0] PA = 32'h0000_1004, TA = 32'hAAAA_0000;
  localparam logic [31:0] PB = 32'h0000_2008, TB = 32'hBBBB_0004;
  localparam logic [31:0] PC = 32'h8000_0FFC, TC = 32'hCCCC_0008;
  localparam logic [31:0] PD = 32'h0040_0010, TD = 32'hDDDD_000C;
  localparam logic [31:0] PE = 32'h1234_5678, TE = 32'hEEEE_0010;

  btb_update_scheduler dut (
    .CLK              (CLK),
    .RESET            (RESET),
    .STALL            (STALL),
    .upd_valid_IN_ID  (upd_valid_IN_ID),
    .upd_PC_IN_ID     (upd_PC_IN_ID),
    .upd_taken_IN_ID  (upd_taken_IN_ID),
    .upd_target_IN_ID (upd_target_IN_ID),
    .upd_ready_OUT    (upd_ready_OUT),
    .inval_all_IN     (inval_all_IN),
    .wr_valid_OUT     (wr_valid_OUT),
    .wr_op_OUT        (wr_op_OUT),
    .wr_index_OUT     (wr_index_OUT),
    .wr_tag_OUT       (wr_tag_OUT),
    .wr_target_OUT    (wr_target_OUT),
    .wr_ready_IN      (wr_ready_IN),
    .busy_OUT         (busy_OUT),
    .sweep_done_OUT   (sweep_done_OUT),
    .drop_count_OUT   (drop_count_OUT)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        stall, v, tk;
    logic [31:0] pc, tgt;
    logic        wrr;
    logic        ev;
    logic [8:0]  eidx;
    logic [20:0] etag;
    logic [31:0] etgt;
    logic        erdy, ebusy;
    logic [15:0] edrop;
  } vec_t;

  typedef struct {
    logic [8:0]  idx;
    logic [20:0] tag;
    logic [31:0] tgt;
  } ment_t;

  vec_t  tbl [14];
  ment_t mq [$];
  ment_t me;
  int    mdrop;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_in();
    STALL            = 1'b0;
    upd_valid_IN_ID  = 1'b0;
    upd_taken_IN_ID  = 1'b0;
    upd_PC_IN_ID     = '0;
    upd_target_IN_ID = '0;
    inval_all_IN     = 1'b0;
  endtask

  task automatic chk_reset(input string nm);
    chk({nm, "_wr"}, {wr_valid_OUT, wr_op_OUT, wr_index_OUT,
                      wr_tag_OUT, wr_target_OUT}, 64'd0);
    chk({nm, "_misc"}, 64'({upd_ready_OUT, busy_OUT, sweep_done_OUT,
                            drop_count_OUT}), 64'({1'b1, 18'd0}));
  endtask

  task automatic do_reset();
    idle_in();
    wr_ready_IN = 1'b0;
    RESET = 1'b1;
    step();
    step();
    chk_reset("reset");
    RESET = 1'b0;
  endtask

  task automatic drive_upd(input logic [31:0] pc, input logic [31:0] tgt);
    upd_valid_IN_ID  = 1'b1;
    upd_taken_IN_ID  = 1'b1;
    upd_PC_IN_ID     = pc;
    upd_target_IN_ID = tgt;
  endtask

  initial begin
    int writes, bad, dones, cyc, hits;
    logic [9:0] exp_i;
    logic req, full, hs;

    tbl[0]  = '{0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0};
    tbl[1]  = '{0, 1, 1, 32'h0040_0010, 32'h0040_0100, 1,
                1, 9'h004, 21'h000800, 32'h0040_0100, 1, 1, 0};
    tbl[2]  = '{0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0};
    tbl[3]  = '{0, 1, 0, PD, TD, 1, 0, 0, 0, 0, 1, 0, 0};
    tbl[4]  = '{1, 1, 1, PD, TD, 1, 0, 0, 0, 0, 1, 0, 0};
    tbl[5]  = '{0, 1, 1, PA, TA, 0, 1, 9'h001, 21'h2, TA, 1, 1, 0};
    tbl[6]  = '{0, 1, 1, PB, TB, 0, 1, 9'h001, 21'h2, TA, 1, 1, 0};
    tbl[7]  = '{0, 1, 1, PC, TC, 0, 1, 9'h001, 21'h2, TA, 1, 1, 0};
    tbl[8]  = '{0, 1, 1, PD, TD, 0, 1, 9'h001, 21'h2, TA, 0, 1, 0};
    tbl[9]  = '{0, 1, 1, PE, TE, 0, 1, 9'h001, 21'h2, TA, 0, 1, 1};
    tbl[10] = '{0, 0, 0, 0, 0, 1, 1, 9'h002, 21'h4, TB, 1, 1, 1};
    tbl[11] = '{0, 0, 0, 0, 0, 1, 1, 9'h1FF, 21'h100001, TC, 1, 1, 1};
    tbl[12] = '{0, 0, 0, 0, 0, 1, 1, 9'h004, 21'h800, TD, 1, 1, 1};
    tbl[13] = '{0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 1};

    do_reset();
    for (int i = 0; i < 14; i++) begin
      STALL            = tbl[i].stall;
      upd_valid_IN_ID  = tbl[i].v;
      upd_taken_IN_ID  = tbl[i].tk;
      upd_PC_IN_ID     = tbl[i].pc;
      upd_target_IN_ID = tbl[i].tgt;
      wr_ready_IN      = tbl[i].wrr;
      step();
      chk($sformatf("vec%0d_valid", i), 64'(wr_valid_OUT), 64'(tbl[i].ev));
      if (tbl[i].ev) begin
        chk($sformatf("vec%0d_wr", i),
            64'({wr_op_OUT, wr_index_OUT, wr_tag_OUT, wr_target_OUT}),
            64'({1'b0, tbl[i].eidx, tbl[i].etag, tbl[i].etgt}));
      end
      chk($sformatf("vec%0d_ready", i), 64'(upd_ready_OUT), 64'(tbl[i].erdy));
      chk($sformatf("vec%0d_busy", i), 64'(busy_OUT), 64'(tbl[i].ebusy));
      chk($sformatf("vec%0d_drop", i), 64'(drop_count_OUT), 64'(tbl[i].edrop));
    end

    // sweep requested while a drain write is held off
    do_reset();
    drive_upd(PA, TA);
    step();
    drive_upd(PB, TB);
    step();
    idle_in();
    inval_all_IN = 1'b1;
    step();
    inval_all_IN = 1'b0;
    chk("sw_hold1", 64'({wr_valid_OUT, wr_op_OUT, wr_index_OUT, wr_target_OUT}),
        64'({1'b1, 1'b0, 9'h001, TA}));
    chk("sw_ready_pend", 64'(upd_ready_OUT), 64'd0);
    step();
    step();
    chk("sw_hold2", 64'({wr_valid_OUT, wr_op_OUT, wr_index_OUT, wr_target_OUT}),
        64'({1'b1, 1'b0, 9'h001, TA}));
    wr_ready_IN = 1'b1;
    step();
    writes = 0;
    bad    = 0;
    dones  = 0;
    cyc    = 0;
    exp_i  = '0;
    while (writes < 512 && cyc < 4000) begin
      wr_ready_IN     = ($urandom_range(3) != 0);
      upd_valid_IN_ID = (cyc == 20);
      upd_taken_IN_ID = 1'b1;
      upd_PC_IN_ID    = PC;
      inval_all_IN    = (cyc == 40);
      if (!wr_valid_OUT || wr_op_OUT !== 1'b1 || wr_index_OUT !== exp_i[8:0]
          || wr_tag_OUT !== '0 || wr_target_OUT !== '0) bad++;
      if (wr_valid_OUT && wr_ready_IN) begin
        writes++;
        exp_i++;
      end
      step();
      cyc++;
      if (sweep_done_OUT) dones++;
    end
    idle_in();
    wr_ready_IN = 1'b0;
    chk("sw_writes", 64'(writes), 64'd512);
    chk("sw_bad_writes", 64'(bad), 64'd0);
    chk("sw_done_now", 64'({sweep_done_OUT, wr_valid_OUT}), 64'b10);
    chk("sw_drop", 64'(drop_count_OUT), 64'd1);
    step();
    chk("sw_done_once", 64'(dones), 64'd1);
    chk("sw_after", 64'({sweep_done_OUT, wr_valid_OUT, busy_OUT, upd_ready_OUT}),
        64'b0001);
    wr_ready_IN = 1'b1;
    hits = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (wr_valid_OUT || sweep_done_OUT) hits++;
    end
    chk("sw_flushed", 64'(hits), 64'd0);

    // reset in the middle of a sweep
    do_reset();
    wr_ready_IN  = 1'b1;
    inval_all_IN = 1'b1;
    step();
    inval_all_IN = 1'b0;
    for (int c = 0; c < 300 && !(wr_valid_OUT && wr_index_OUT == 9'd100); c++)
      step();
    chk("rs_reach100", 64'({wr_valid_OUT, wr_index_OUT}), 64'({1'b1, 9'd100}));
    RESET = 1'b1;
    step();
    chk_reset("rs_mid");
    RESET = 1'b0;
    hits = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (wr_valid_OUT || sweep_done_OUT) hits++;
    end
    chk("rs_quiet", 64'(hits), 64'd0);

    // randomized traffic against an in-order queue model
    do_reset();
    mq.delete();
    mdrop = 0;
    for (int c = 0; c < 2000; c++) begin
      chk("rnd_valid", 64'(wr_valid_OUT), 64'(mq.size() != 0));
      chk("rnd_ready", 64'(upd_ready_OUT), 64'(mq.size() < 4));
      chk("rnd_busy", 64'(busy_OUT), 64'(mq.size() != 0));
      chk("rnd_drop", 64'(drop_count_OUT), 64'(mdrop));
      if (mq.size() != 0) begin
        chk("rnd_wr", 64'({wr_op_OUT, wr_index_OUT, wr_tag_OUT, wr_target_OUT}),
            64'({1'b0, mq[0].idx, mq[0].tag, mq[0].tgt}));
      end
      STALL            = ($urandom_range(7) == 0);
      upd_valid_IN_ID  = ($urandom_range(2) != 0);
      upd_taken_IN_ID  = ($urandom_range(3) != 0);
      upd_PC_IN_ID     = $urandom;
      upd_target_IN_ID = $urandom;
      wr_ready_IN      = ($urandom_range(2) == 0);
      req  = upd_valid_IN_ID && upd_taken_IN_ID && !STALL;
      full = (mq.size() >= 4);
      hs   = (mq.size() != 0) && wr_ready_IN;
      if (req) begin
        if (!full) begin
          me.idx = 9'((upd_PC_IN_ID / 4) % 512);
          me.tag = 21'(upd_PC_IN_ID / 2048);
          me.tgt = upd_target_IN_ID;
          mq.push_back(me);
        end else if (mdrop < 65535) begin
          mdrop++;
        end
      end
      if (hs) void'(mq.pop_front());
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/btb_update_scheduler.md
Name: btb_update_scheduler

Overview:
- Controller that owns the single write port of the branch target buffer.
- Takes resolved-taken branch updates from the ID stage, buffers them in a small FIFO, and presents them to the BTB one at a time over a valid/ready write handshake.
- Also sequences a full-table invalidation sweep on request.
- This removes ad-hoc writes triggered by ID-stage edges and gives the BTB exactly one clocked writer.

Parameters:
- DEPTH, 4, number of pending-update FIFO entries (power of 2, ≥2).
- SETS, 512, number of BTB sets walked by a sweep.
- INDEX_BITS, 9, log2(SETS); set index = PC[INDEX_BITS+1:2].
- TAG_BITS, 21, tag = PC[31:INDEX_BITS+2].

Ports:
- CLK  in  1  clock, all state on posedge.
- RESET  in  1  synchronous, active-high reset.
- STALL  in  1  pipeline stall; when high, no update is enqueued or dropped.
- upd_valid_IN_ID  in  1  ID stage holds a resolved branch.
- upd_PC_IN_ID  in  32  PC of that branch.
- upd_taken_IN_ID  in  1  branch resolved taken.
- upd_target_IN_ID  in  32  resolved target PC.
- upd_ready_OUT  out  1  FIFO can accept (count<DEPTH and state≠SWEEP and no sweep pending).
- inval_all_IN  in  1  single-cycle request to invalidate every BTB set.
- wr_valid_OUT  out  1  write command valid.
- wr_op_OUT  out  1  0 = install (tag, target), 1 = invalidate both ways of set.
- wr_index_OUT  out  INDEX_BITS  set index.
- wr_tag_OUT  out  TAG_BITS  tag; 0 when wr_op_OUT=1.
- wr_target_OUT  out  32  target PC; 0 when wr_op_OUT=1.
- wr_ready_IN  in  1  BTB accepts the write this cycle.
- busy_OUT  out  1  state≠IDLE or count≠0.
- sweep_done_OUT  out  1  one-cycle pulse after the last sweep write is accepted.
- drop_count_OUT  out  16  saturating count of rejected taken updates.

Behaviour:
- Reset: all outputs 0 except upd_ready_OUT=1. FIFO is emptied, state=IDLE, sweep-pending flag cleared, sweep counter=0. Reset mid-sweep or mid-handshake aborts immediately; no further writes are issued.
- Enqueue condition: upd_valid_IN_ID & upd_taken_IN_ID & !STALL & upd_ready_OUT. Stores {index, tag, target}.
- Not-taken updates are ignored and not counted.
- Drop condition: enqueue condition with upd_ready_OUT=0. drop_count_OUT increments and saturates at 16'hFFFF.
- upd_ready_OUT is computed from registered count only. A pop in the same cycle does not free a slot for that cycle's enqueue when full.
- Write outputs are registered. Handshake completes on wr_valid_OUT & wr_ready_IN.
- Once wr_valid_OUT=1, wr_op, wr_index, wr_tag and wr_target stay stable until accepted. No retraction, including when inval_all_IN arrives.
- FSM states:
  - IDLE:
    - if the sweep-pending flag is set, or inval_all_IN=1, go to SWEEP.
    - else if count>0, load the head entry into the wr_* registers, set wr_valid_OUT, go to DRAIN.
  - DRAIN:
    - on handshake, pop the head.
    - then, if sweep pending, go to SWEEP.
    - else if count>0, present the next entry in the following cycle (back-to-back: one write per cycle when wr_ready_IN stays high).
    - else go to IDLE with wr_valid_OUT=0.
  - SWEEP:
    - on entry, the FIFO is flushed (discarded entries are not counted as drops) and the sweep counter is set to 0.
    - presents wr_op=1, wr_index=counter; the counter advances on each handshake.
    - after the handshake at index SETS-1: wr_valid_OUT=0, sweep_done_OUT=1 for one cycle, clear pending, go to IDLE.
    - inval_all_IN during SWEEP is ignored.
- inval_all_IN outside SWEEP sets the sweep-pending flag. The request is latched, so an in-flight DRAIN write completes first.
- Latency: an update enqueued at cycle N with an empty FIFO and state IDLE appears on wr_* at cycle N+1.
- Simultaneous enqueue and pop at 0<count<DEPTH: count is unchanged and order is preserved (strict FIFO).
- Pointers wrap modulo DEPTH.
- STALL does not freeze the write side. Draining and sweeping continue during STALL.

Test Plan:
- Enqueue PC=0x00400010, taken, target=0x00400100, wr_ready_IN=1 → next cycle wr_valid=1, op=0, index=0x004, tag=0x000800, target=0x00400100, then busy_OUT returns to 0.
- Hold wr_ready_IN=0 and enqueue 5 taken updates (DEPTH=4) → upd_ready_OUT=0 after 4 are accepted, drop_count_OUT=1 (head is in the wr_* registers but counted until popped), wr_* stable throughout. Release ready → 4 writes in order on consecutive cycles.
- Not-taken update, and taken update with STALL=1 → no write, drop_count unchanged.
- inval_all_IN while a DRAIN write is stalled (wr_ready_IN=0) with 2 entries queued → that write completes, the remaining entry is discarded, 512 op=1 writes with index 0..511, sweep_done_OUT pulses once, drop_count unchanged.
- Taken update during SWEEP → rejected, drop_count +1.
- Assert RESET at sweep index 100 → next cycle all outputs 0, upd_ready_OUT=1, no sweep_done pulse.
